// File: rtl/lcd_img_proc.sv
// lcd_img_proc
// Image-buffer controller for the display path. After reset it loads an
// IMG_W x IMG_H image of DW-bit pixels from the image ROM. It then accepts host
// commands that either move a 2x2 operating window or rewrite the four pixels
// under it. On WRITE it streams the whole buffer to the image RAM, and after
// each dump it returns to accepting commands.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   cmd, cmd_valid       command code and strobe, taken when busy=0
//   busy                 high while loading, executing or writing
//   done                 one-cycle pulse on the cycle after the last RAM write
//   IROM_rd/IROM_A/Q     image ROM read port (data one cycle after address)
//   IRAM_valid/A/D       image RAM write port (registered)
module lcd_img_proc #(
   parameter  int DW    = 8,
   parameter  int IMG_W = 8,
   parameter  int IMG_H = 8,
   localparam int AW    = $clog2(IMG_W*IMG_H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    cmd,
   input  logic          cmd_valid,
   output logic          busy,
   output logic          done,
   output logic          IROM_rd,
   output logic [AW-1:0] IROM_A,
   input  logic [DW-1:0] IROM_Q,
   output logic          IRAM_valid,
   output logic [AW-1:0] IRAM_A,
   output logic [DW-1:0] IRAM_D
);

   localparam int N  = IMG_W*IMG_H;
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   localparam logic [XW-1:0] X_MAX  = XW'(IMG_W-2);
   localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H-2);
   localparam logic [XW-1:0] X_RST  = XW'(IMG_W/2-1);
   localparam logic [YW-1:0] Y_RST  = YW'(IMG_H/2-1);
   localparam logic [AW:0]   N_CNT  = (AW+1)'(N);
   localparam logic [AW-1:0] A_LAST = AW'(N-1);

   localparam logic [2:0] S_LOAD  = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [3:0] C_WRITE = 4'd0;
   localparam logic [3:0] C_UP    = 4'd1;
   localparam logic [3:0] C_DOWN  = 4'd2;
   localparam logic [3:0] C_LEFT  = 4'd3;
   localparam logic [3:0] C_RIGHT = 4'd4;
   localparam logic [3:0] C_MAX   = 4'd5;
   localparam logic [3:0] C_MIN   = 4'd6;
   localparam logic [3:0] C_AVG   = 4'd7;
   localparam logic [3:0] C_CCW   = 4'd8;
   localparam logic [3:0] C_CW    = 4'd9;
   localparam logic [3:0] C_MIRX  = 4'd10;
   localparam logic [3:0] C_MIRY  = 4'd11;
   localparam logic [3:0] C_INC   = 4'd12;
   localparam logic [3:0] C_DEC   = 4'd13;

   function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   function automatic logic [DW-1:0] sat_dec(input logic [DW-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [DW-1:0] umin(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (a < b) ? a : b;
   endfunction

   // Floor average: two guard bits keep the four-way sum exact.
   function automatic logic [DW-1:0] avg4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [DW-1:0] c, input logic [DW-1:0] d);
      logic [DW+1:0] s;
      s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
      return s[DW+1:2];
   endfunction

   logic [2:0]    state;
   logic [AW:0]   rd_cnt;
   logic [AW:0]   wr_cnt;
   logic [3:0]    cmd_q;
   logic [XW-1:0] wx;
   logic [YW-1:0] wy;
   logic [XW-1:0] wx1;
   logic [YW-1:0] wy1;
   logic          vld_p1;
   logic [AW-1:0] cap_a_p1;

   logic [DW-1:0] pix_mem [N];

   logic [AW-1:0] a0, a1, a2, a3;
   logic [DW-1:0] p0, p1, p2, p3;
   logic [DW-1:0] n0, n1, n2, n3;
   logic [DW-1:0] w_max, w_min, w_avg;

   // Power-of-two width makes y*IMG_W+x a plain concatenation.
   assign wx1 = wx + 1'b1;
   assign wy1 = wy + 1'b1;
   assign a0  = {wy,  wx};
   assign a1  = {wy,  wx1};
   assign a2  = {wy1, wx};
   assign a3  = {wy1, wx1};

   assign p0 = pix_mem[a0];
   assign p1 = pix_mem[a1];
   assign p2 = pix_mem[a2];
   assign p3 = pix_mem[a3];

   assign w_max = umax(umax(p0, p1), umax(p2, p3));
   assign w_min = umin(umin(p0, p1), umin(p2, p3));
   assign w_avg = avg4(p0, p1, p2, p3);

   // New window contents; every op is built only from pre-update pixels.
   always_comb begin
      n0 = p0;
      n1 = p1;
      n2 = p2;
      n3 = p3;
      case (cmd_q)
         C_MAX: begin n0 = w_max; n1 = w_max; n2 = w_max; n3 = w_max; end
         C_MIN: begin n0 = w_min; n1 = w_min; n2 = w_min; n3 = w_min; end
         C_AVG: begin n0 = w_avg; n1 = w_avg; n2 = w_avg; n3 = w_avg; end
         C_CCW: begin n0 = p1; n1 = p3; n3 = p2; n2 = p0; end
         C_CW:  begin n0 = p2; n2 = p3; n3 = p1; n1 = p0; end
         C_MIRX: begin n0 = p2; n2 = p0; n1 = p3; n3 = p1; end
         C_MIRY: begin n0 = p1; n1 = p0; n2 = p3; n3 = p2; end
         C_INC: begin
            n0 = sat_inc(p0); n1 = sat_inc(p1); n2 = sat_inc(p2); n3 = sat_inc(p3);
         end
         C_DEC: begin
            n0 = sat_dec(p0); n1 = sat_dec(p1); n2 = sat_dec(p2); n3 = sat_dec(p3);
         end
         default: ;
      endcase
   end

   // Stage p1: ROM data lands one cycle after its address was issued.
   always_ff @(posedge clk) begin
      if (vld_p1)
         pix_mem[cap_a_p1] <= IROM_Q;
      if (state == S_EXEC) begin
         pix_mem[a0] <= n0;
         pix_mem[a1] <= n1;
         pix_mem[a2] <= n2;
         pix_mem[a3] <= n3;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_LOAD;
         busy       <= 1'b1;
         done       <= 1'b0;
         IROM_rd    <= 1'b0;
         IROM_A     <= '0;
         IRAM_valid <= 1'b0;
         IRAM_A     <= '0;
         IRAM_D     <= '0;
         rd_cnt     <= '0;
         wr_cnt     <= '0;
         cmd_q      <= '0;
         wx         <= X_RST;
         wy         <= Y_RST;
         vld_p1     <= 1'b0;
         cap_a_p1   <= '0;
      end else begin
         vld_p1   <= IROM_rd;
         cap_a_p1 <= IROM_A;
         case (state)
            S_LOAD: begin
               if (rd_cnt < N_CNT) begin
                  IROM_rd <= 1'b1;
                  IROM_A  <= rd_cnt[AW-1:0];
                  rd_cnt  <= rd_cnt + 1'b1;
               end else begin
                  IROM_rd <= 1'b0;
               end
               if (vld_p1 && (cap_a_p1 == A_LAST)) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_IDLE: begin
               if (cmd_valid && !busy) begin
                  cmd_q <= cmd;
                  busy  <= 1'b1;
                  if (cmd == C_WRITE) begin
                     state  <= S_WRITE;
                     wr_cnt <= '0;
                  end else begin
                     state <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               // Shifts saturate at the edges: the window never wraps.
               case (cmd_q)
                  C_UP:    if (wy != '0)    wy <= wy - 1'b1;
                  C_DOWN:  if (wy != Y_MAX) wy <= wy + 1'b1;
                  C_LEFT:  if (wx != '0)    wx <= wx - 1'b1;
                  C_RIGHT: if (wx != X_MAX) wx <= wx + 1'b1;
                  default: ;
               endcase
            end
            S_WRITE: begin
               if (wr_cnt < N_CNT) begin
                  IRAM_valid <= 1'b1;
                  IRAM_A     <= wr_cnt[AW-1:0];
                  IRAM_D     <= pix_mem[wr_cnt[AW-1:0]];
                  wr_cnt     <= wr_cnt + 1'b1;
               end else begin
                  IRAM_valid <= 1'b0;
                  done       <= 1'b1;
                  state      <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_img_proc.sv
// Testbench for lcd_img_proc: default 8x8/8-bit instance driven through the
// command set with a buffer model and RAM-stream scoreboard, plus a 16x4/10-bit
// instance exercising load and WRITE.
module tb_lcd_img_proc;

   localparam int DW = 8;
   localparam int N  = 64;
   localparam int AW = 6;

   typedef struct {
      int a;
      int d;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [3:0]    cmd = 4'd0;
   logic          cmd_valid = 1'b0;
   logic          busy, done, IROM_rd, IRAM_valid;
   logic [AW-1:0] IROM_A, IRAM_A;
   logic [DW-1:0] IROM_Q, IRAM_D;

   logic          reset_b = 1'b0;
   logic [3:0]    cmd_b = 4'd0;
   logic          cmd_valid_b = 1'b0;
   logic          busy_b, done_b, IROM_rd_b, IRAM_valid_b;
   logic [5:0]    IROM_A_b, IRAM_A_b;
   logic [9:0]    IROM_Q_b, IRAM_D_b;

   logic [DW-1:0] rom [N];
   logic [DW-1:0] mb  [N];
   logic [DW-1:0] ram [N];
   exp_t          sb[$];
   int            mx, my;
   int            irom_exp;
   int            b_cnt;
   int            n_chk = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   lcd_img_proc dut (
      .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
      .busy(busy), .done(done), .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
      .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A), .IRAM_D(IRAM_D)
   );

   lcd_img_proc #(.DW(10), .IMG_W(16), .IMG_H(4)) dut_b (
      .clk(clk), .reset(reset_b), .cmd(cmd_b), .cmd_valid(cmd_valid_b),
      .busy(busy_b), .done(done_b), .IROM_rd(IROM_rd_b), .IROM_A(IROM_A_b), .IROM_Q(IROM_Q_b),
      .IRAM_valid(IRAM_valid_b), .IRAM_A(IRAM_A_b), .IRAM_D(IRAM_D_b)
   );

   always_ff @(posedge clk) begin
      if (IROM_rd)   IROM_Q   <= rom[IROM_A];
      if (IROM_rd_b) IROM_Q_b <= {4'b0000, IROM_A_b};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ROM address sequence during every load, and the RAM stream scoreboard.
   always @(negedge clk) begin
      if (!reset && IROM_rd) begin
         check("irom_a", IROM_A, irom_exp);
         irom_exp++;
      end
      if (!reset && IRAM_valid) begin
         if (sb.size() == 0) begin
            check("iram_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("iram_a", IRAM_A, e.a);
            check("iram_d", IRAM_D, e.d);
         end
         ram[IRAM_A] = IRAM_D;
      end
      if (!reset_b && IRAM_valid_b) begin
         check("b_iram_a", IRAM_A_b, b_cnt);
         check("b_iram_d", IRAM_D_b, b_cnt);
         b_cnt++;
      end
   end

   task automatic model_cmd(input int c);
      int            idx [4];
      logic [DW-1:0] p [4];
      logic [DW-1:0] q [4];
      int            s;
      idx[0] = my*8 + mx; idx[1] = idx[0] + 1; idx[2] = idx[0] + 8; idx[3] = idx[2] + 1;
      for (int j = 0; j < 4; j++) begin
         p[j] = mb[idx[j]];
         q[j] = p[j];
      end
      case (c)
         0: for (int k = 0; k < N; k++) sb.push_back('{a: k, d: int'(mb[k])});
         1: if (my > 0) my--;
         2: if (my < 6) my++;
         3: if (mx > 0) mx--;
         4: if (mx < 6) mx++;
         5, 6: begin
            s = p[0];
            for (int j = 1; j < 4; j++)
               if ((c == 5) ? (p[j] > s) : (p[j] < s)) s = p[j];
            for (int j = 0; j < 4; j++) q[j] = DW'(s);
         end
         7: begin
            s = p[0] + p[1] + p[2] + p[3];
            for (int j = 0; j < 4; j++) q[j] = DW'(s / 4);
         end
         8:  begin q[0] = p[1]; q[1] = p[3]; q[3] = p[2]; q[2] = p[0]; end
         9:  begin q[0] = p[2]; q[2] = p[3]; q[3] = p[1]; q[1] = p[0]; end
         10: begin q[0] = p[2]; q[2] = p[0]; q[1] = p[3]; q[3] = p[1]; end
         11: begin q[0] = p[1]; q[1] = p[0]; q[2] = p[3]; q[3] = p[2]; end
         12: for (int j = 0; j < 4; j++) q[j] = (p[j] == 255) ? 8'd255 : p[j] + 8'd1;
         13: for (int j = 0; j < 4; j++) q[j] = (p[j] == 0) ? 8'd0 : p[j] - 8'd1;
         default: ;
      endcase
      for (int j = 0; j < 4; j++) mb[idx[j]] = q[j];
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
      if (!ok) check("idle_timeout", 0, 1);
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      cmd = 4'd0;
      reset = 1'b1;
      #1;
      check("rst_busy", busy, 1);
      check("rst_done", done, 0);
      check("rst_irom_rd", IROM_rd, 0);
      check("rst_irom_a", IROM_A, 0);
      check("rst_iram_valid", IRAM_valid, 0);
      check("rst_iram_a", IRAM_A, 0);
      check("rst_iram_d", IRAM_D, 0);
      sb.delete();
      for (int k = 0; k < N; k++) mb[k] = rom[k];
      mx = 3; my = 3;
      repeat (2) @(negedge clk);
      irom_exp = 0;
      reset = 1'b0;
      wait_idle();
      check("load_count", irom_exp, N);
   endtask

   task automatic wait_write(input bit jam);
      bit ok = 0;
      for (int i = 0; i < N + 20; i++) begin
         if (done) begin ok = 1; break; end
         if (jam) begin cmd = 4'd3; cmd_valid = 1'b1; end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      if (!ok) begin
         check("done_timeout", 0, 1);
      end else begin
         check("done_busy", busy, 1);
         check("done_iram_valid", IRAM_valid, 0);
         check("done_iram_a_hold", IRAM_A, N - 1);
         check("sb_drained", sb.size(), 0);
         @(negedge clk);
         check("done_pulse_end", done, 0);
         check("post_done_busy", busy, 0);
      end
   endtask

   task automatic send(input int c, input bit jam = 0);
      wait_idle();
      cmd = 4'(c);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      model_cmd(c);
      @(negedge clk);
      if (c == 0) begin
         wait_write(jam);
      end else begin
         check("exec_busy", busy, 1);
         @(negedge clk);
         check("exec_release", busy, 0);
      end
   endtask

   initial begin
      #2;
      reset_b = 1'b1;

      // Identity image: WRITE streams D=A.
      for (int k = 0; k < N; k++) rom[k] = DW'(k);
      do_reset();
      send(0);
      check("ram_id_63", ram[63], 63);

      // MAX at the reset origin (3,3).
      send(5);
      send(0);
      check("max_27", ram[27], 36);
      check("max_28", ram[28], 36);
      check("max_35", ram[35], 36);
      check("max_36", ram[36], 36);
      check("max_26", ram[26], 26);

      // Clamp at the top-left corner, then AVG.
      do_reset();
      repeat (5) send(3);
      repeat (5) send(1);
      send(7);
      send(0);
      check("avg_0", ram[0], 4);
      check("avg_1", ram[1], 4);
      check("avg_8", ram[8], 4);
      check("avg_9", ram[9], 4);
      check("avg_2", ram[2], 2);

      // Saturating brightness.
      for (int k = 0; k < N; k++) rom[k] = 8'd255;
      rom[27] = 8'd254;
      do_reset();
      send(12);
      send(0);
      check("inc_sat_27", ram[27], 255);
      check("inc_sat_28", ram[28], 255);
      send(12);
      send(13);
      send(0);
      check("dec_27", ram[27], 254);
      check("dec_28", ram[28], 254);
      check("dec_35", ram[35], 254);
      check("dec_36", ram[36], 254);

      // Rotations, mirrors, ignored commands during WRITE, bottom-right clamp.
      for (int k = 0; k < N; k++) rom[k] = DW'(k);
      do_reset();
      send(9);
      send(0);
      check("cw_27", ram[27], 35);
      check("cw_28", ram[28], 27);
      check("cw_35", ram[35], 36);
      check("cw_36", ram[36], 28);
      send(8);
      send(10);
      send(10);
      send(0, 1);
      check("restore_27", ram[27], 27);
      check("restore_35", ram[35], 35);
      send(11);
      send(14);
      repeat (5) send(4);
      repeat (5) send(2);
      send(6);
      send(0);
      check("miry_27", ram[27], 28);
      check("miry_28", ram[28], 27);
      check("min_54", ram[54], 54);
      check("min_55", ram[55], 54);
      check("min_63", ram[63], 54);

      // Reset in the middle of a WRITE.
      begin
         bit hit = 0;
         wait_idle();
         cmd = 4'd0;
         cmd_valid = 1'b1;
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
         model_cmd(0);
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (IRAM_valid && IRAM_A == 6'd20) begin hit = 1; break; end
         end
         check("midwrite_reached", hit, 1);
         reset = 1'b1;
         #1;
         check("midrst_iram_valid", IRAM_valid, 0);
         check("midrst_busy", busy, 1);
         check("midrst_iram_a", IRAM_A, 0);
         check("midrst_irom_rd", IROM_rd, 0);
         sb.delete();
         for (int k = 0; k < N; k++) mb[k] = rom[k];
         mx = 3; my = 3;
         repeat (2) @(negedge clk);
         irom_exp = 0;
         reset = 1'b0;
         wait_idle();
         check("reload_count", irom_exp, N);
         send(0);
      end

      // 16x4, 10-bit instance.
      begin
         bit ok = 0;
         b_cnt = 0;
         @(negedge clk);
         reset_b = 1'b0;
         for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_b) begin ok = 1; break; end
         end
         check("b_load_idle", ok, 1);
         cmd_b = 4'd0;
         cmd_valid_b = 1'b1;
         @(posedge clk);
         #1;
         cmd_valid_b = 1'b0;
         ok = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_b) begin ok = 1; break; end
         end
         check("b_done", ok, 1);
         check("b_count", b_cnt, 64);
         check("b_done_busy", busy_b, 1);
         @(negedge clk);
         check("b_done_end", done_b, 0);
         check("b_idle", busy_b, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
